esc_quad_pwm: RTL and testbench

Consumer end of the flight-control speed path. Takes the four 11-bit unsigned motor speeds and converts each into a servo-style PWM pulse for an ESC. All four channels share one period counter. Pulse-width updates are double-buffered so they only take effect at period boundaries. Sits between the flight controller and the four ESC pins at top level.

---
 rtl/esc_quad_pwm.sv | 147 ++++++++++++++
 tb/tb_esc_quad_pwm.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_quad_pwm.sv
// Four-channel servo-style ESC PWM generator: one shared period counter, widths double-buffered at the wrap.
// Define ESC_SLEW_EN to rate-limit each channel's effective speed by SLEW_STEP per period.
module esc_quad_pwm #(
    parameter int PERIOD_W  = 20,
    parameter int BASE_CNT  = 50000,
    parameter int SPD_MULT  = 3,
    parameter int SLEW_STEP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        armed,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        frnt_pwm,
    output logic        bck_pwm,
    output logic        lft_pwm,
    output logic        rght_pwm,
    output logic        frm_strt
);

    localparam int SPD_W  = 11;
    localparam int NCH    = 4;
    localparam int PROD_W = PERIOD_W + 16;
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
    localparam logic [PERIOD_W-1:0] CMP_MAX = CNT_MAX - 1'b1;
    localparam logic [PERIOD_W-1:0] BASE    = PERIOD_W'(BASE_CNT);

    // Saturate below the wrap so every pulse has a falling edge inside its period.
    function automatic logic [PERIOD_W-1:0] speed_to_cmp(input logic [SPD_W-1:0] spd);
        logic [PROD_W-1:0] raw;
        raw = PROD_W'(spd) * PROD_W'(SPD_MULT) + PROD_W'(BASE_CNT);
        if (raw > PROD_W'(CMP_MAX))
            return CMP_MAX;
        return raw[PERIOD_W-1:0];
    endfunction

    logic [SPD_W-1:0]    spd_in     [NCH];
    logic [SPD_W-1:0]    spd_p0     [NCH];
    logic [SPD_W-1:0]    stage2_spd [NCH];
    logic [PERIOD_W-1:0] cmp_nxt_p1 [NCH];
    logic [PERIOD_W-1:0] cmp_act_p2 [NCH];
    logic [NCH-1:0]      pwm_q;
    logic [PERIOD_W-1:0] cnt;
    logic                frm_strt_q;
    logic                wrap;

    assign spd_in[0] = frnt_spd;
    assign spd_in[1] = bck_spd;
    assign spd_in[2] = lft_spd;
    assign spd_in[3] = rght_spd;
    assign wrap      = (cnt == CNT_MAX);

    // Stage 1: capture commanded speeds, disarmed forces zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) spd_p0[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) spd_p0[i] <= armed ? spd_in[i] : '0;
        end
    end

`ifdef ESC_SLEW_EN
    function automatic logic [SPD_W-1:0] slew_toward(input logic [SPD_W-1:0] eff,
                                                     input logic [SPD_W-1:0] req);
        logic [SPD_W-1:0] step;
        step = SPD_W'(SLEW_STEP);
        if (req > eff)
            return (req - eff > step) ? eff + step : req;
        return (eff - req > step) ? eff - step : req;
    endfunction

    logic             armed_p0;
    logic [SPD_W-1:0] eff_tgt    [NCH];
    logic [SPD_W-1:0] eff_nxt_p1 [NCH];
    logic [SPD_W-1:0] eff_p2     [NCH];

    // Disarm bypasses the slew limiter and drops straight to zero.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            eff_tgt[i]    = armed_p0 ? slew_toward(eff_p2[i], spd_p0[i]) : '0;
            stage2_spd[i] = eff_tgt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_p0 <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                eff_nxt_p1[i] <= '0;
                eff_p2[i]     <= '0;
            end
        end else begin
            armed_p0 <= armed;
            for (int i = 0; i < NCH; i++) begin
                eff_nxt_p1[i] <= eff_tgt[i];
                if (wrap) eff_p2[i] <= eff_nxt_p1[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NCH; i++) stage2_spd[i] = spd_p0[i];
    end
`endif

    // Stage 2: compare value from speed; active compare swaps only at the wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cmp_nxt_p1[i] <= BASE;
                cmp_act_p2[i] <= BASE;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cmp_nxt_p1[i] <= speed_to_cmp(stage2_spd[i]);
                if (wrap) cmp_act_p2[i] <= cmp_nxt_p1[i];
            end
        end
    end

    // Output stage: shared counter, pulses high for cnt = 1..cmp_active
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            frm_strt_q <= 1'b0;
            pwm_q      <= '0;
        end else begin
            cnt        <= cnt + 1'b1;
            frm_strt_q <= (cnt == '0);
            for (int i = 0; i < NCH; i++) begin
                if (cnt == '0)
                    pwm_q[i] <= 1'b1;
                else if (cnt == cmp_act_p2[i])
                    pwm_q[i] <= 1'b0;
            end
        end
    end

    assign frnt_pwm = pwm_q[0];
    assign bck_pwm  = pwm_q[1];
    assign lft_pwm  = pwm_q[2];
    assign rght_pwm = pwm_q[3];
    assign frm_strt = frm_strt_q;

endmodule

// File: tb/tb_esc_quad_pwm.sv
// Self-checking bench for esc_quad_pwm with a shortened period; pulse widths are
// measured per period and compared against a sampling-point reference model.
`timescale 1ns/1ps
module tb_esc_quad_pwm;

    localparam int PW   = 11;
    localparam int BASE = 100;
    localparam int MULT = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        armed = 1'b0;
    logic [10:0] spd [4];
    logic        frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frm_strt;
    logic [3:0]  pw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    esc_quad_pwm #(
        .PERIOD_W(PW), .BASE_CNT(BASE), .SPD_MULT(MULT), .SLEW_STEP(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .armed(armed),
        .frnt_spd(spd[0]), .bck_spd(spd[1]), .lft_spd(spd[2]), .rght_spd(spd[3]),
        .frnt_pwm(frnt_pwm), .bck_pwm(bck_pwm), .lft_pwm(lft_pwm), .rght_pwm(rght_pwm),
        .frm_strt(frm_strt)
    );

    assign pw = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};

    // Reference: width for a period is fixed by inputs seen at cnt = PMAX-2 of the prior period.
    function automatic int wid(input int s);
        int v;
        v = s * MULT + BASE;
        if (v > PMAX - 1) v = PMAX - 1;
        return v;
    endfunction

    int tb_cnt = 0;
    int exp_nxt [4];
    int exp_cur [4];

    always @(posedge clk) begin
        if (!rst_n) begin
            tb_cnt = 0;
            for (int c = 0; c < 4; c++) begin
                exp_cur[c] = BASE;
                exp_nxt[c] = BASE;
            end
        end else begin
            if (tb_cnt == PMAX - 2)
                for (int c = 0; c < 4; c++) exp_nxt[c] = armed ? wid(int'(spd[c])) : BASE;
            if (tb_cnt == PMAX)
                for (int c = 0; c < 4; c++) exp_cur[c] = exp_nxt[c];
            tb_cnt = (tb_cnt + 1) & PMAX;
        end
    end

    // Period monitor: per-channel high time, period length and expected widths
    int   mw_q[$];
    int   me_q[$];
    int   len_q[$];
    int   hi [4];
    int   per_exp [4];
    int   cyc = 0;
    int   bad_rise = 0;
    bit   tracking = 0;
    logic [3:0] pw_prev = 4'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            tracking = 0;
        end else if (frm_strt === 1'b1) begin
            if (tracking) begin
                len_q.push_back(cyc);
                for (int c = 0; c < 4; c++) begin
                    mw_q.push_back(hi[c]);
                    me_q.push_back(per_exp[c]);
                end
            end
            if (pw !== 4'hF) bad_rise++;
            for (int c = 0; c < 4; c++) begin
                hi[c]      = 1;
                per_exp[c] = exp_cur[c];
            end
            cyc      = 1;
            tracking = 1;
        end else if (tracking) begin
            cyc++;
            for (int c = 0; c < 4; c++)
                if (pw[c] === 1'b1) begin
                    hi[c]++;
                    if (pw_prev[c] !== 1'b1) bad_rise++;
                end
        end
        pw_prev = pw;
    end

    int rw [4];
    int re [4];
    int rlen;
    bit rok;

    task automatic get_rec();
        int n;
        n = 0;
        while (len_q.size() == 0 && n < 2 * (PMAX + 1) + 20) begin
            @(negedge clk); #1;
            n++;
        end
        rok = (len_q.size() != 0);
        if (rok) begin
            rlen = len_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                rw[c] = mw_q.pop_front();
                re[c] = me_q.pop_front();
            end
        end
    endtask

    task automatic sync_period();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (frm_strt !== 1'b1 && n < PMAX + 20);
        checks++;
        if (frm_strt !== 1'b1) begin
            errors++;
            $display("FAIL sync_frm_strt got=%b want=1", frm_strt);
        end
        @(negedge clk); #1;
        mw_q.delete(); me_q.delete(); len_q.delete();
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (tb_cnt != v && n < PMAX + 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (tb_cnt != v) begin
            errors++;
            $display("FAIL wait_cnt got=%0d want=%0d", tb_cnt, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; armed = 1'b1;
        for (int c = 0; c < 4; c++) spd[c] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pw !== 4'h0) begin errors++; $display("FAIL reset_pwm got=%h want=0", pw); end
        checks++;
        if (frm_strt !== 1'b0) begin errors++; $display("FAIL reset_frm got=%b want=0", frm_strt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (frm_strt !== 1'b1) begin errors++; $display("FAIL first_frm got=%b want=1", frm_strt); end
        checks++;
        if (pw !== 4'hF) begin errors++; $display("FAIL first_rise got=%h want=F", pw); end
        @(posedge clk); #1;
        checks++;
        if (frm_strt !== 1'b0) begin errors++; $display("FAIL frm_one_cycle got=%b want=0", frm_strt); end
    endtask

    task automatic test_base();
        for (int p = 0; p < 2; p++) begin
            get_rec();
            checks++;
            if (!rok) begin errors++; $display("FAIL base_timeout got=none want=record"); return; end
            checks++;
            if (rlen != PMAX + 1) begin errors++; $display("FAIL base_len got=%0d want=%0d", rlen, PMAX + 1); end
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (rw[c] != BASE) begin errors++; $display("FAIL base_w ch%0d got=%0d want=%0d", c, rw[c], BASE); end
            end
        end
    endtask

    task automatic test_speed();
        int s;
        s = $urandom_range(900, 1);
        sync_period();
        spd[0] = 11'(s);
        for (int p = 0; p < 3; p++) begin
            get_rec();
            checks++;
            if (!rok) begin errors++; $display("FAIL speed_timeout got=none want=record"); return; end
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (rw[c] != ((c == 0 && p > 0) ? s * MULT + BASE : BASE)) begin
                    errors++;
                    $display("FAIL speed_w p%0d ch%0d got=%0d want=%0d", p, c, rw[c],
                             (c == 0 && p > 0) ? s * MULT + BASE : BASE);
                end
            end
        end
        spd[0] = '0;
    endtask

    task automatic test_mid_change();
        int r;
        int exp_r [5];
        exp_r = '{BASE, PMAX - 1, PMAX - 1, PMAX - 1, BASE};
        sync_period();
        wait_cnt(PMAX / 3);
        spd[3] = 11'h7FF;
        for (int p = 0; p < 5; p++) begin
            get_rec();
            checks++;
            if (!rok) begin errors++; $display("FAIL mid_timeout got=none want=record"); return; end
            checks++;
            if (rw[3] != exp_r[p]) begin errors++; $display("FAIL mid_rght p%0d got=%0d want=%0d", p, rw[3], exp_r[p]); end
            // late change lands two boundaries out
            if (p == 1) begin
                wait_cnt(PMAX - 1);
                spd[3] = '0;
            end
        end
        r = $urandom_range(2047, 1);
        wait_cnt(PMAX - 2);
        spd[2] = 11'(r);
        for (int p = 0; p < 2; p++) begin
            get_rec();
            checks++;
            if (!rok) begin errors++; $display("FAIL edge_timeout got=none want=record"); return; end
            checks++;
            if (rw[2] != (p == 0 ? BASE : wid(r))) begin
                errors++;
                $display("FAIL edge_lft p%0d got=%0d want=%0d", p, rw[2], p == 0 ? BASE : wid(r));
            end
        end
        spd[2] = '0;
    endtask

    task automatic test_armed();
        armed = 1'b0;
        for (int c = 0; c < 4; c++) spd[c] = 11'h200;
        for (int p = 0; p < 4; p++) begin
            get_rec();
            checks++;
            if (!rok) begin errors++; $display("FAIL armed_timeout got=none want=record"); return; end
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (p == 0) begin
                    if (rw[c] != re[c]) begin errors++; $display("FAIL armed_w p0 ch%0d got=%0d want=%0d", c, rw[c], re[c]); end
                end else if (rw[c] != (p == 3 ? 'h200 * MULT + BASE : BASE)) begin
                    errors++;
                    $display("FAIL armed_w p%0d ch%0d got=%0d want=%0d", p, c, rw[c], p == 3 ? 'h200 * MULT + BASE : BASE);
                end
            end
            if (p == 1) armed = 1'b1;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            wait_cnt($urandom_range(PMAX, 3));
            armed = ($urandom_range(3, 0) != 0);
            for (int c = 0; c < 4; c++) spd[c] = 11'($urandom_range(2047, 0));
            get_rec();
            checks++;
            if (!rok) begin errors++; $display("FAIL rand_timeout got=none want=record"); return; end
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (rw[c] != re[c]) begin errors++; $display("FAIL rand_w k%0d ch%0d got=%0d want=%0d", k, c, rw[c], re[c]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        armed = 1'b1;
        for (int c = 0; c < 4; c++) spd[c] = 11'($urandom_range(900, 200));
        sync_period();
        sync_period();
        wait_cnt(BASE / 2);
        checks++;
        if (pw !== 4'hF) begin errors++; $display("FAIL rstmid_high got=%h want=F", pw); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pw !== 4'h0) begin errors++; $display("FAIL rstmid_pwm got=%h want=0", pw); end
        checks++;
        if (frm_strt !== 1'b0) begin errors++; $display("FAIL rstmid_frm got=%b want=0", frm_strt); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (frm_strt !== 1'b1 || pw !== 4'hF) begin
            errors++;
            $display("FAIL rstmid_rise got=%b/%h want=1/F", frm_strt, pw);
        end
        @(negedge clk); #1;
        mw_q.delete(); me_q.delete(); len_q.delete();
        get_rec();
        checks++;
        if (!rok) begin errors++; $display("FAIL rstmid_timeout got=none want=record"); return; end
        checks++;
        if (rlen != PMAX + 1) begin errors++; $display("FAIL rstmid_len got=%0d want=%0d", rlen, PMAX + 1); end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rw[c] != BASE) begin errors++; $display("FAIL rstmid_w ch%0d got=%0d want=%0d", c, rw[c], BASE); end
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) spd[c] = '0;
        test_reset();
        test_base();
        test_speed();
        test_mid_change();
        test_armed();
        test_random();
        test_reset_mid();
        checks++;
        if (bad_rise != 0) begin errors++; $display("FAIL rise_align got=%0d want=0", bad_rise); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
